// File: rtl/present_pool_ctrl.sv
// present_pool_ctrl
// Manages a pool of present (power-up) slots. A dropPresent request claims the
// lowest-index free slot, pulses its presentReset for one cycle, latches a
// pseudo-random type and then runs the slot through ACTIVE and BLINK until it
// is picked up, hit by the rope or times out.
//
// Ports
//   clk                 system clock
//   reset               asynchronous, active-high reset
//   startOfFrame        one-cycle pulse per video frame
//   dropPresent         one-cycle spawn request
//   col_player_present  per-slot player collision level
//   col_rope_present    per-slot rope collision level
//   presentVisible      per-slot draw enable
//   presentReset        per-slot one-cycle reposition pulse (DEPLOY)
//   present_type        per-slot type, slot i at [i*TYPE_W +: TYPE_W]
//   col_present         pulse: any qualified collision in the previous cycle
//   collected           per-slot pickup pulse
//   collected_type      type of the lowest-index collected slot (0 if none)
//   dropMissed          pulse: spawn request with no free slot
module present_pool_ctrl #(
    parameter int          N_PRESENTS   = 3,
    parameter int          TYPE_W       = 2,
    parameter int          LIFE_FRAMES  = 300,
    parameter int          BLINK_FRAMES = 60,
    parameter int          BLINK_PERIOD = 8,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         startOfFrame,
    input  logic                         dropPresent,
    input  logic [N_PRESENTS-1:0]        col_player_present,
    input  logic [N_PRESENTS-1:0]        col_rope_present,
    output logic [N_PRESENTS-1:0]        presentVisible,
    output logic [N_PRESENTS-1:0]        presentReset,
    output logic [N_PRESENTS*TYPE_W-1:0] present_type,
    output logic                         col_present,
    output logic [N_PRESENTS-1:0]        collected,
    output logic [TYPE_W-1:0]            collected_type,
    output logic                         dropMissed
);

    localparam int MAX_FRAMES = (LIFE_FRAMES > BLINK_FRAMES) ? LIFE_FRAMES : BLINK_FRAMES;
    localparam int BLINK_BIT  = $clog2(BLINK_PERIOD);
    localparam int CNT_W_A    = $clog2(MAX_FRAMES + 1);
    // Counter must be wide enough to hold the blink phase bit as well
    localparam int CNT_W      = (CNT_W_A > BLINK_BIT + 1) ? CNT_W_A : BLINK_BIT + 1;
    localparam logic [CNT_W-1:0] LIFE_LAST  = CNT_W'(LIFE_FRAMES - 1);
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DEPLOY = 2'd1,
        S_ACTIVE = 2'd2,
        S_BLINK  = 2'd3
    } slot_state_t;

    slot_state_t                 state_r     [N_PRESENTS];
    slot_state_t                 state_nxt_s [N_PRESENTS];
    logic [CNT_W-1:0]            cnt_r       [N_PRESENTS];
    logic [CNT_W-1:0]            cnt_nxt_s   [N_PRESENTS];
    logic [15:0]                 lfsr_r;
    logic [N_PRESENTS-1:0]       idle_s;
    logic [N_PRESENTS-1:0]       alloc_s;
    logic                        any_idle_s;
    logic [N_PRESENTS-1:0]       hit_s;
    logic [N_PRESENTS-1:0]       pick_s;
    logic [N_PRESENTS-1:0]       visible_nxt_s;
    logic [N_PRESENTS-1:0]       deploy_nxt_s;
    logic [N_PRESENTS*TYPE_W-1:0] type_nxt_s;
    logic [TYPE_W-1:0]           ctype_s;

    // Fibonacci LFSR, taps 16,14,13,11
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    // Allocation: isolate the lowest set bit of the idle mask
    always_comb begin
        for (int i = 0; i < N_PRESENTS; i++) begin
            idle_s[i] = (state_r[i] == S_IDLE);
        end
        any_idle_s = |idle_s;
        alloc_s    = dropPresent ? (idle_s & (~idle_s + N_PRESENTS'(1))) : {N_PRESENTS{1'b0}};
    end

    // Per-slot next-state, frame counter and derived output values
    always_comb begin
        for (int i = 0; i < N_PRESENTS; i++) begin
            state_nxt_s[i] = state_r[i];
            cnt_nxt_s[i]   = cnt_r[i];
            // Collisions only count once the object is on screen
            hit_s[i]  = ((state_r[i] == S_ACTIVE) || (state_r[i] == S_BLINK)) &&
                        (col_player_present[i] || col_rope_present[i]);
            pick_s[i] = hit_s[i] && col_player_present[i];
            case (state_r[i])
                S_IDLE: begin
                    if (alloc_s[i]) begin
                        state_nxt_s[i] = S_DEPLOY;
                        cnt_nxt_s[i]   = {CNT_W{1'b0}};
                    end else begin
                        state_nxt_s[i] = S_IDLE;
                    end
                end
                S_DEPLOY: begin
                    state_nxt_s[i] = S_ACTIVE;
                    cnt_nxt_s[i]   = {CNT_W{1'b0}};
                end
                S_ACTIVE: begin
                    // Collision takes priority over the lifetime counter
                    if (hit_s[i]) begin
                        state_nxt_s[i] = S_IDLE;
                        cnt_nxt_s[i]   = {CNT_W{1'b0}};
                    end else if (startOfFrame) begin
                        if (cnt_r[i] >= LIFE_LAST) begin
                            state_nxt_s[i] = S_BLINK;
                            cnt_nxt_s[i]   = {CNT_W{1'b0}};
                        end else begin
                            cnt_nxt_s[i] = cnt_r[i] + CNT_W'(1);
                        end
                    end else begin
                        state_nxt_s[i] = S_ACTIVE;
                    end
                end
                S_BLINK: begin
                    if (hit_s[i]) begin
                        state_nxt_s[i] = S_IDLE;
                        cnt_nxt_s[i]   = {CNT_W{1'b0}};
                    end else if (startOfFrame) begin
                        if (cnt_r[i] >= BLINK_LAST) begin
                            state_nxt_s[i] = S_IDLE;
                            cnt_nxt_s[i]   = {CNT_W{1'b0}};
                        end else begin
                            cnt_nxt_s[i] = cnt_r[i] + CNT_W'(1);
                        end
                    end else begin
                        state_nxt_s[i] = S_BLINK;
                    end
                end
                default: begin
                    state_nxt_s[i] = S_IDLE;
                    cnt_nxt_s[i]   = {CNT_W{1'b0}};
                end
            endcase
            visible_nxt_s[i] = (state_nxt_s[i] == S_ACTIVE) ||
                               ((state_nxt_s[i] == S_BLINK) && !cnt_nxt_s[i][BLINK_BIT]);
            deploy_nxt_s[i]  = (state_nxt_s[i] == S_DEPLOY);
            // Type is captured from the LFSR during the DEPLOY cycle
            if (state_r[i] == S_DEPLOY) begin
                type_nxt_s[i*TYPE_W +: TYPE_W] = lfsr_r[TYPE_W-1:0];
            end else begin
                type_nxt_s[i*TYPE_W +: TYPE_W] = present_type[i*TYPE_W +: TYPE_W];
            end
        end
    end

    // Type of the lowest-index picked-up slot; scanning downwards lets index 0 win
    always_comb begin
        ctype_s = {TYPE_W{1'b0}};
        for (int i = N_PRESENTS - 1; i >= 0; i--) begin
            if (pick_s[i]) begin
                ctype_s = present_type[i*TYPE_W +: TYPE_W];
            end else begin
                ctype_s = ctype_s;
            end
        end
    end

    // Slot state and frame counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_PRESENTS; i++) begin
                state_r[i] <= S_IDLE;
                cnt_r[i]   <= {CNT_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < N_PRESENTS; i++) begin
                state_r[i] <= state_nxt_s[i];
                cnt_r[i]   <= cnt_nxt_s[i];
            end
        end
    end

    // Free-running type LFSR
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_r <= LFSR_SEED;
        end else begin
            lfsr_r <= lfsr_step(lfsr_r);
        end
    end

    // Registered outputs, computed from next-state values so they track the slot state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presentVisible <= {N_PRESENTS{1'b0}};
            presentReset   <= {N_PRESENTS{1'b0}};
            present_type   <= {(N_PRESENTS*TYPE_W){1'b0}};
            col_present    <= 1'b0;
            collected      <= {N_PRESENTS{1'b0}};
            collected_type <= {TYPE_W{1'b0}};
            dropMissed     <= 1'b0;
        end else begin
            presentVisible <= visible_nxt_s;
            presentReset   <= deploy_nxt_s;
            present_type   <= type_nxt_s;
            col_present    <= |hit_s;
            collected      <= pick_s;
            collected_type <= ctype_s;
            dropMissed     <= dropPresent & ~any_idle_s;
        end
    end

endmodule

// File: tb/tb_present_pool_ctrl.sv
module tb_present_pool_ctrl;

    localparam int          N      = 3;
    localparam int          TW     = 2;
    localparam logic [15:0] SEED   = 16'hACE1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          startOfFrame = 1'b0;
    logic          dropPresent = 1'b0;
    logic [N-1:0]  col_player_present = '0;
    logic [N-1:0]  col_rope_present = '0;
    logic [N-1:0]  presentVisible;
    logic [N-1:0]  presentReset;
    logic [N*TW-1:0] present_type;
    logic          col_present;
    logic [N-1:0]  collected;
    logic [TW-1:0] collected_type;
    logic          dropMissed;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] m_lfsr;
    logic [TW-1:0] t0, t1, t2;

    present_pool_ctrl #(
        .N_PRESENTS(N), .TYPE_W(TW), .LIFE_FRAMES(4), .BLINK_FRAMES(16),
        .BLINK_PERIOD(8), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .dropPresent(dropPresent),
        .col_player_present(col_player_present), .col_rope_present(col_rope_present),
        .presentVisible(presentVisible), .presentReset(presentReset),
        .present_type(present_type), .col_present(col_present), .collected(collected),
        .collected_type(collected_type), .dropMissed(dropMissed)
    );

    always #5 clk = ~clk;

    // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11
    always @(posedge clk or posedge reset) begin
        if (reset) m_lfsr <= SEED;
        else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        tick();
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_visible", 32'(presentVisible), 32'd0);
        chk("rst_preset", 32'(presentReset), 32'd0);
        chk("rst_type", 32'(present_type), 32'd0);
        chk("rst_misc", {29'd0, col_present, dropMissed, |collected}, 32'd0);
        reset = 1'b0;
        tick();

        // Test 1: single drop -> slot0 DEPLOY then visible
        dropPresent = 1'b1;
        tick();
        dropPresent = 1'b0;
        t0 = m_lfsr[TW-1:0];
        chk("t1_preset", 32'(presentReset), 32'b001);
        chk("t1_vis_deploy", 32'(presentVisible), 32'b000);
        tick();
        chk("t1_preset_off", 32'(presentReset), 32'b000);
        chk("t1_visible", 32'(presentVisible), 32'b001);
        chk("t1_type", 32'(present_type[1:0]), 32'(t0));

        // Test 2: fill remaining slots, fourth drop misses
        dropPresent = 1'b1;
        tick();
        t1 = m_lfsr[TW-1:0];
        chk("t2_preset1", 32'(presentReset), 32'b010);
        tick();
        t2 = m_lfsr[TW-1:0];
        chk("t2_preset2", 32'(presentReset), 32'b100);
        chk("t2_nomiss", 32'(dropMissed), 32'd0);
        tick();
        dropPresent = 1'b0;
        chk("t2_missed", 32'(dropMissed), 32'd1);
        chk("t2_preset_none", 32'(presentReset), 32'b000);
        chk("t2_types", 32'(present_type), 32'({t2, t1, t0}));
        tick();
        chk("t2_missed_off", 32'(dropMissed), 32'd0);
        chk("t2_visible_all", 32'(presentVisible), 32'b111);

        // Test 3: player+rope on slot1 -> collected, pulse even with persistent level
        col_player_present = 3'b010;
        col_rope_present   = 3'b010;
        tick();
        chk("t3_collected", 32'(collected), 32'b010);
        chk("t3_col_present", 32'(col_present), 32'd1);
        chk("t3_ctype", 32'(collected_type), 32'(t1));
        chk("t3_visible", 32'(presentVisible), 32'b101);
        tick();
        chk("t3_collected_off", 32'(collected), 32'b000);
        chk("t3_col_present_off", 32'(col_present), 32'd0);
        col_player_present = 3'b000;
        col_rope_present   = 3'b000;

        // Freed slot1 is re-allocated as the lowest idle slot
        dropPresent = 1'b1;
        tick();
        dropPresent = 1'b0;
        t1 = m_lfsr[TW-1:0];
        chk("realloc_preset", 32'(presentReset), 32'b010);
        tick();
        chk("realloc_visible", 32'(presentVisible), 32'b111);
        chk("realloc_type", 32'(present_type[3:2]), 32'(t1));

        // Test 6: slots 0 and 2 picked up in the same cycle
        col_player_present = 3'b101;
        tick();
        col_player_present = 3'b000;
        chk("t6_collected", 32'(collected), 32'b101);
        chk("t6_ctype", 32'(collected_type), 32'(t0));
        chk("t6_col_present", 32'(col_present), 32'd1);
        chk("t6_visible", 32'(presentVisible), 32'b010);
        tick();
        chk("t6_collected_off", 32'(collected), 32'b000);
        chk("t6_ctype_off", 32'(collected_type), 32'd0);

        // Test 4: slot1 lifetime, 4 frames active, 8 on / 8 off blinking, then idle
        for (int f = 1; f <= 20; f++) begin
            frame();
            chk($sformatf("t4_vis_f%0d", f), 32'(presentVisible), (f <= 11) ? 32'b010 : 32'b000);
        end
        chk("t4_no_collect", 32'(collected), 32'b000);
        // Expired slot must ignore collisions
        col_player_present = 3'b010;
        tick();
        col_player_present = 3'b000;
        chk("t4_idle_col", 32'(col_present), 32'd0);
        chk("t4_idle_collected", 32'(collected), 32'b000);

        // Test 5: collision during DEPLOY is ignored, then reset mid-ACTIVE
        dropPresent = 1'b1;
        tick();
        dropPresent = 1'b0;
        chk("t5_preset", 32'(presentReset), 32'b001);
        col_player_present = 3'b001;
        col_rope_present   = 3'b001;
        tick();
        col_player_present = 3'b000;
        col_rope_present   = 3'b000;
        chk("t5_deploy_col", 32'(col_present), 32'd0);
        chk("t5_deploy_collected", 32'(collected), 32'b000);
        chk("t5_active", 32'(presentVisible), 32'b001);
        reset = 1'b1;
        #1;
        chk("t5_rst_visible", 32'(presentVisible), 32'd0);
        chk("t5_rst_type", 32'(present_type), 32'd0);
        chk("t5_rst_misc", {28'd0, col_present, dropMissed, |collected, |presentReset}, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("t5_post_visible", 32'(presentVisible), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
